universal_buffer_reg: RTL
=========================

Name: universal_buffer_reg

Overview:
Parametrised successor to the controlled buffer register. It keeps the clocked parallel load and synchronous clear, and adds multi-mode shifting (logical, arithmetic, rotate) with serial in/out. An internal sequencer applies a requested operation n times, one step per clock, and flags completion. It sits in the register library as the general-purpose storage/serialiser element for datapath and serial-link blocks.

Parameters:
buff_len, 8, register width in bits (>= 2)
cnt_w, $clog2(buff_len)+1, width of the step-count input n

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-low reset; clears all state when 0 at a rising edge
x  input  buff_len  parallel load data
load  input  1  parallel load strobe; q <= x at the next edge
start  input  1  request a shift operation; sampled only in IDLE
mode  input  3  operation selector, latched at start
n  input  cnt_w  number of single-bit steps, latched at start
sin  input  1  serial input bit, sampled live on each logical shift step
q  output  buff_len  register contents
so  output  1  serial output: bit expelled or wrapped by the most recent step
busy  output  1  high while the sequencer is in SHIFT
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: clr=0 at an edge -> q=0, so=0, busy=0, done=0, state=IDLE, count=0. Reset dominates load/start, including mid-operation.
- Priority at each edge (clr=1): load > sequencer step > start > hold.
- Mode encodings:
  - 000: hold (steps consume count, q unchanged, so unchanged).
  - 001: logical shift right, sin -> MSB, LSB -> so.
  - 010: logical shift left, sin -> LSB, MSB -> so.
  - 011: rotate right, LSB -> MSB, so = LSB.
  - 100: rotate left, MSB -> LSB, so = MSB.
  - 101: arithmetic shift right, MSB replicated, sin ignored, so = LSB.
  - 110, 111: reserved, behave as 000.
- States: IDLE, SHIFT, DONE. All outputs registered.
- IDLE:
  - start=1 and n != 0 -> SHIFT; latch mode; count = n. No step on this edge.
  - start=1 and n = 0 -> DONE. No step, q unchanged.
- SHIFT: each edge applies one step and decrements count. The edge where count goes 1->0 performs the last step and moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state == SHIFT). For start sampled at edge k with n>0:
  - Steps occur at edges k+1 .. k+n.
  - busy is high for n cycles after edge k.
  - done is high in the cycle after edge k+n.
- Latched mode/n are immune to input changes during SHIFT. sin is sampled per step.
- start while busy or in DONE: ignored, not queued.
- load=1 in SHIFT or DONE:
  - q <= x; so unchanged; state -> IDLE; count cleared.
  - No done pulse for the aborted operation.
  - load with start in IDLE: load wins, start dropped.
- n > buff_len is legal; every step is still applied. Rotates wrap modulo buff_len; logical shifts fully flush to sin; arithmetic shift saturates to all-MSB.
- load alone in IDLE: q <= x at next edge, 1-cycle latency; so, busy, done unaffected.

Test Plan:
- Reset/load: clr=0 for 2 edges, then x=8'h96, load=1 for 1 edge -> q=0 during reset; q=8'h96 next cycle; so=0, busy=0, done=0.
- Logical right: q=8'h96, start, mode=001, n=3, sin=1 -> busy high 3 cycles; intermediate q=8'hCB, 8'hE5; final q=8'hF2; so=1; done pulses 1 cycle, then IDLE.
- Rotate/arith with n > width:
  - q=8'h81, mode=100, n=10 -> q=8'h06 after 10 steps, busy for 10 cycles.
  - q=8'h80, mode=101, n=9 -> q=8'hFF.
- Edge cases:
  - n=0 with start -> done next cycle, busy never high, q unchanged.
  - start asserted while busy -> ignored; exactly one done pulse.
  - mode changed mid-op -> no effect.
- Abort by load: mode=010, n=5 on 8'h01; assert load with x=8'h3C after 2 steps -> q=8'h3C; busy drops next cycle; no done pulse; a following start works normally.
- Reset mid-operation: clr=0 during SHIFT -> q=0, so=0, busy=0, done=0 on that edge; sequencer idle afterwards.

Source files
------------

// File: rtl/universal_buffer_reg.sv
// Universal buffer register: parallel load and synchronous clear, plus a
// sequencer that applies logical/arithmetic/rotate shifts n times, one step per clock.
`timescale 1ns/1ps
module universal_buffer_reg #(
    parameter int buff_len = 8,
    parameter int cnt_w    = $clog2(buff_len) + 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [buff_len-1:0] x,
    input  logic                load,
    input  logic                start,
    input  logic [2:0]          mode,
    input  logic [cnt_w-1:0]    n,
    input  logic                sin,
    output logic [buff_len-1:0] q,
    output logic                so,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LSR  = 3'b001,
        OP_LSL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ASR  = 3'b101
    } op_t;

    state_t              state;
    op_t                 mode_r;
    logic [cnt_w-1:0]    count;
    logic [buff_len-1:0] step_q;
    logic                step_so;

    // Single-step result for the latched operation; reserved encodings hold.
    always_comb begin
        step_q  = q;
        step_so = so;
        case (mode_r)
            OP_LSR: begin
                step_q  = {sin, q[buff_len-1:1]};
                step_so = q[0];
            end
            OP_LSL: begin
                step_q  = {q[buff_len-2:0], sin};
                step_so = q[buff_len-1];
            end
            OP_ROR: begin
                step_q  = {q[0], q[buff_len-1:1]};
                step_so = q[0];
            end
            OP_ROL: begin
                step_q  = {q[buff_len-2:0], q[buff_len-1]};
                step_so = q[buff_len-1];
            end
            OP_ASR: begin
                step_q  = {q[buff_len-1], q[buff_len-1:1]};
                step_so = q[0];
            end
            default: begin
                step_q  = q;
                step_so = so;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q      <= '0;
            so     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            state  <= IDLE;
            count  <= '0;
            mode_r <= OP_HOLD;
        end else if (load) begin
            // Load wins over everything and silently aborts any operation.
            q     <= x;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_r <= op_t'(mode);
                        if (n != '0) begin
                            count <= n;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    q     <= step_q;
                    so    <= step_so;
                    count <= count - 1'b1;
                    if (count == cnt_w'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
